// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS-lite core: walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives the datapath control lines.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       npcsel,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             ext_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wd_sel,
  output logic             mem_we,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             illegal,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state_q, next_state;

  logic is_rtype, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

  logic       ir_en, retire, reg_en, mem_en, set_illegal;
  logic [1:0] npcsel_c;

  assign is_rtype = (opcode == 6'b000000);
  assign is_addu  = is_rtype && (funct == 6'b100001);
  assign is_subu  = is_rtype && (funct == 6'b100011);
  assign is_jr    = is_rtype && (funct == 6'b001000);
  assign is_nop   = is_rtype && (funct == 6'b000000);
  assign is_ori   = (opcode == 6'b001101);
  assign is_lui   = (opcode == 6'b001111);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_beq   = (opcode == 6'b000100);
  assign is_j     = (opcode == 6'b000010);
  assign is_jal   = (opcode == 6'b000011);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state_q <= next_state;
      if (retire)
        retired <= retired + CNT_W'(1);
      if (set_illegal)
        illegal <= 1'b1;
    end
  end

  // Every retiring path leaves next_state at its FETCH default.
  always_comb begin
    next_state  = FETCH;
    ir_en       = 1'b0;
    retire      = 1'b0;
    reg_en      = 1'b0;
    mem_en      = 1'b0;
    set_illegal = 1'b0;
    npcsel_c    = 2'b00;
    alu_op      = 2'b00;
    alu_src     = 1'b0;
    ext_op      = 1'b0;
    reg_dst     = 2'b00;
    wd_sel      = 2'b00;

    case (state_q)
      FETCH: begin
        ir_en      = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        if (is_j) begin
          retire   = 1'b1;
          npcsel_c = 2'b10;
        end else if (is_jr) begin
          retire   = 1'b1;
          npcsel_c = 2'b11;
        end else if (is_jal) begin
          next_state = WB;
        end else if (is_addu || is_subu || is_ori || is_lui ||
                     is_lw || is_sw || is_beq) begin
          next_state = EXEC;
        end else begin
          retire      = 1'b1;
          set_illegal = !is_nop;
        end
      end
      EXEC: begin
        if (is_subu || is_beq)
          alu_op = 2'b01;
        else if (is_ori)
          alu_op = 2'b10;
        alu_src = is_ori || is_lw || is_sw;
        ext_op  = is_lw || is_sw;
        if (is_beq) begin
          retire   = 1'b1;
          npcsel_c = zero ? 2'b01 : 2'b00;
        end else if (is_lw || is_sw) begin
          next_state = MEM;
        end else begin
          next_state = WB;
        end
      end
      MEM: begin
        // Hold the address computation stable while the memory is accessed.
        alu_src = is_lw || is_sw;
        ext_op  = is_lw || is_sw;
        if (is_sw) begin
          mem_en = 1'b1;
          retire = 1'b1;
        end else if (is_lw) begin
          next_state = WB;
        end
      end
      WB: begin
        reg_en = 1'b1;
        retire = 1'b1;
        if (is_addu || is_subu) begin
          reg_dst = 2'b01;
          alu_op  = is_subu ? 2'b01 : 2'b00;
        end else if (is_ori) begin
          alu_op  = 2'b10;
          alu_src = 1'b1;
        end else if (is_lui) begin
          wd_sel = 2'b11;
        end else if (is_lw) begin
          wd_sel = 2'b01;
        end else if (is_jal) begin
          reg_dst  = 2'b10;
          wd_sel   = 2'b10;
          npcsel_c = 2'b10;
        end
      end
      default: ;
    endcase
  end

  // Enables are gated by reset so an in-flight write drops without a clock edge.
  assign ir_we      = ir_en  && reset;
  assign pc_we      = retire && reset;
  assign instr_done = retire && reset;
  assign reg_we     = reg_en && reset;
  assign mem_we     = mem_en && reset;
  assign npcsel     = reset ? npcsel_c : 2'b00;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed sequences plus random instruction
// stream, each instruction checked against a per-class timing/control model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;

  logic        ir_we, pc_we, alu_src, ext_op, reg_we, mem_we, instr_done, illegal;
  logic [1:0]  npcsel, alu_op, reg_dst, wd_sel;
  logic [31:0] retired;
  logic [2:0]  state;

  logic        ir_we4, pc_we4, alu_src4, ext_op4, reg_we4, mem_we4, instr_done4, illegal4;
  logic [1:0]  npcsel4, alu_op4, reg_dst4, wd_sel4;
  logic [3:0]  retired4;
  logic [2:0]  state4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int count = 0;
  logic ill_m = 1'b0;

  // Instruction classes: 0 addu,1 subu,2 jr,3 nop,4 ori,5 lui,6 lw,7 sw,
  // 8 beq,9 j,10 jal,11 illegal opcode,12 illegal R-type funct
  logic [5:0] tab_op [0:12] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23,
                                6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h00};
  logic [5:0] tab_fn [0:12] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};

  int         m_len;
  logic [2:0] m_st [0:4];
  logic [1:0] m_npc, m_dst, m_wd, m_aluop;
  logic       m_regwe, m_memwe, m_src, m_ext, m_ill;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(ir_we), .pc_we(pc_we), .npcsel(npcsel), .alu_op(alu_op),
    .alu_src(alu_src), .ext_op(ext_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .mem_we(mem_we), .instr_done(instr_done),
    .retired(retired), .illegal(illegal), .state(state)
  );

  mc_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .ir_we(ir_we4), .pc_we(pc_we4), .npcsel(npcsel4), .alu_op(alu_op4),
    .alu_src(alu_src4), .ext_op(ext_op4), .reg_we(reg_we4), .reg_dst(reg_dst4),
    .wd_sel(wd_sel4), .mem_we(mem_we4), .instr_done(instr_done4),
    .retired(retired4), .illegal(illegal4), .state(state4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_seq(input int n, input logic [2:0] s2, input logic [2:0] s3,
                         input logic [2:0] s4);
    m_len = n;
    m_st[0] = 3'd0;
    m_st[1] = 3'd1;
    m_st[2] = s2;
    m_st[3] = s3;
    m_st[4] = s4;
  endtask

  // Expected behaviour of one instruction class, straight from its description.
  task automatic model(input int k, input logic z);
    m_npc = 2'b00; m_dst = 2'b00; m_wd = 2'b00; m_aluop = 2'b00;
    m_regwe = 1'b0; m_memwe = 1'b0; m_src = 1'b0; m_ext = 1'b0; m_ill = 1'b0;
    case (k)
      0:  begin set_seq(4, 3'd2, 3'd4, 3'd0); m_regwe = 1; m_dst = 2'b01; end
      1:  begin set_seq(4, 3'd2, 3'd4, 3'd0); m_regwe = 1; m_dst = 2'b01; m_aluop = 2'b01; end
      2:  begin set_seq(2, 3'd0, 3'd0, 3'd0); m_npc = 2'b11; end
      3:  begin set_seq(2, 3'd0, 3'd0, 3'd0); end
      4:  begin set_seq(4, 3'd2, 3'd4, 3'd0); m_regwe = 1; m_aluop = 2'b10; m_src = 1; end
      5:  begin set_seq(4, 3'd2, 3'd4, 3'd0); m_regwe = 1; m_wd = 2'b11; end
      6:  begin set_seq(5, 3'd2, 3'd3, 3'd4); m_regwe = 1; m_wd = 2'b01; m_src = 1; m_ext = 1; end
      7:  begin set_seq(4, 3'd2, 3'd3, 3'd0); m_memwe = 1; m_src = 1; m_ext = 1; end
      8:  begin set_seq(3, 3'd2, 3'd0, 3'd0); m_aluop = 2'b01; m_npc = z ? 2'b01 : 2'b00; end
      9:  begin set_seq(2, 3'd0, 3'd0, 3'd0); m_npc = 2'b10; end
      10: begin set_seq(3, 3'd4, 3'd0, 3'd0); m_regwe = 1; m_dst = 2'b10; m_wd = 2'b10; m_npc = 2'b10; end
      default: begin set_seq(2, 3'd0, 3'd0, 3'd0); m_ill = 1; end
    endcase
  endtask

  // Runs one instruction from its FETCH cycle; entered just after a rising edge.
  task automatic applyStimulus(input int k, input logic z, output int retire_cyc);
    logic last;
    opcode = tab_op[k];
    funct  = (k == 4 || (k >= 5 && k <= 11)) ? 6'($urandom_range(0, 63)) : tab_fn[k];
    zero   = z;
    model(k, z);
    for (int i = 0; i < m_len; i++) begin
      @(negedge clk);
      cyc++;
      last = (i == m_len - 1);
      check("state", 32'(state), 32'(m_st[i]));
      check("ir_we", 32'(ir_we), 32'(i == 0));
      check("pc_we", 32'(pc_we), 32'(last));
      check("instr_done", 32'(instr_done), 32'(last));
      check("mem_we", 32'(mem_we), 32'(last && m_memwe));
      check("reg_we", 32'(reg_we), 32'(last && m_regwe));
      if (m_st[i] == 3'd2 || m_st[i] == 3'd3) begin
        check("alu_op", 32'(alu_op), 32'(m_aluop));
        check("alu_src", 32'(alu_src), 32'(m_src));
        check("ext_op", 32'(ext_op), 32'(m_ext));
      end
      if (last) begin
        check("npcsel", 32'(npcsel), 32'(m_npc));
        if (m_regwe) begin
          check("reg_dst", 32'(reg_dst), 32'(m_dst));
          check("wd_sel", 32'(wd_sel), 32'(m_wd));
        end
      end
    end
    retire_cyc = cyc;
    @(posedge clk);
    #1;
    count++;
    ill_m = ill_m | m_ill;
    checkOutput();
  endtask

  task automatic checkOutput();
    check("retired", retired, 32'(count));
    check("retired4", 32'(retired4), 32'(count % 16));
    check("illegal", 32'(illegal), 32'(ill_m));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
    count = 0;
    ill_m = 1'b0;
  endtask

  initial begin
    int rc;
    int n;
    logic seen_mem;

    // Reset held low for three cycles
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_enables", {27'd0, ir_we, pc_we, reg_we, mem_we, instr_done}, 32'd0);
      check("rst_npcsel", 32'(npcsel), 32'd0);
      check("rst_retired", retired, 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
    end
    release_reset();

    // ori, addu, sw, lw retire at cycles 4, 8, 12, 17
    applyStimulus(4, 1'b0, rc);  check("retire_cyc_ori", 32'(rc), 32'd4);
    applyStimulus(0, 1'b0, rc);  check("retire_cyc_addu", 32'(rc), 32'd8);
    applyStimulus(7, 1'b0, rc);  check("retire_cyc_sw", 32'(rc), 32'd12);
    applyStimulus(6, 1'b0, rc);  check("retire_cyc_lw", 32'(rc), 32'd17);
    check("retired_after_seq", retired, 32'd4);

    // Branches, jal/jr, illegal opcode followed by a legal instruction
    applyStimulus(8, 1'b1, rc);
    applyStimulus(8, 1'b0, rc);
    applyStimulus(10, 1'b0, rc);
    applyStimulus(2, 1'b0, rc);
    applyStimulus(11, 1'b0, rc);
    applyStimulus(0, 1'b0, rc);
    check("illegal_sticky", 32'(illegal), 32'd1);
    applyStimulus(12, 1'b0, rc);
    applyStimulus(9, 1'b0, rc);
    applyStimulus(3, 1'b0, rc);
    applyStimulus(5, 1'b0, rc);
    applyStimulus(1, 1'b0, rc);

    // Random instruction stream
    for (int i = 0; i < 40; i++)
      applyStimulus(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), rc);

    // Reset pulled low during the MEM cycle of sw
    opcode = 6'h2b;
    funct = 6'h00;
    n = 0;
    seen_mem = 1'b0;
    while (!seen_mem && n < 6) begin
      @(negedge clk);
      n++;
      seen_mem = (state == 3'd3);
    end
    check("reached_mem", 32'(seen_mem), 32'd1);
    check("mem_we_before", 32'(mem_we), 32'd1);
    check("retired_unchanged", retired, 32'(count));
    #1 reset = 1'b0;
    #1;
    check("mem_we_async_drop", 32'(mem_we), 32'd0);
    check("done_async_drop", 32'(instr_done), 32'd0);
    check("state_async_fetch", 32'(state), 32'd0);
    check("retired_cleared", retired, 32'd0);
    check("illegal_cleared", 32'(illegal), 32'd0);
    release_reset();

    // 17 retires wrap the 4-bit counter to 1
    for (int i = 0; i < 17; i++)
      applyStimulus(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)), rc);
    check("wrap_retired4", 32'(retired4), 32'd1);
    check("wide_retired", retired, 32'd17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS-lite core.
- Sequences IR latch, PC update, ALU, data memory and register-file write across per-instruction states.
- Drives the fetch unit's npcsel/PC-write interface; PC holds the current instruction address until retire.
- Instruction set: addu, subu, jr, nop, ori, lui, lw, sw, beq, j, jal.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU equality flag, valid in EXEC
ir_we  out  1  latch instruction register
pc_we  out  1  PC update strobe; fetch unit loads next PC per npcsel
npcsel  out  2  00 PC+4, 01 branch, 10 jump imm26, 11 rs
alu_op  out  2  00 add, 01 sub, 10 or
alu_src  out  1  0 rt value, 1 extended imm
ext_op  out  1  0 zero-extend, 1 sign-extend
reg_we  out  1  GRF write enable
reg_dst  out  2  00 rt, 01 rd, 10 $31
wd_sel  out  2  00 ALU, 01 mem data, 10 PC+4, 11 {imm16,16'b0}
mem_we  out  1  DM write enable
instr_done  out  1  one-cycle pulse on retire (coincides with pc_we)
retired  out  CNT_W  retired-instruction count
illegal  out  1  sticky: unsupported opcode/funct seen
state  out  3  current state, debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5-7 unreachable; if entered, next state FETCH with all enables 0.
- reset=0 (async): state<=FETCH, retired<=0, illegal<=0. While reset=0, ir_we, pc_we, reg_we, mem_we, instr_done are forced 0; npcsel=00. First FETCH executes on the first rising edge after release.
- Outputs are combinational from state, opcode, funct and zero. Only state, retired and illegal are registers.
- Defaults (all states): enables 0, npcsel=00, alu_op=00, alu_src=0, ext_op=0, reg_dst=00, wd_sel=00.
- FETCH: ir_we=1; next DECODE.
- DECODE: decodes the latched IR.
  - j: pc_we=1, npcsel=10, retire.
  - jr (R, funct 001000): pc_we=1, npcsel=11, retire.
  - nop (R, funct 000000): pc_we=1, npcsel=00, retire.
  - jal: next WB.
  - All other legal instructions: next EXEC.
  - Illegal opcode/funct: illegal<=1, handled as nop.
- EXEC: ALU controls held valid.
  - addu: alu_op=00. subu: alu_op=01. ori: alu_op=10, alu_src=1, ext_op=0. lui: none.
  - lw/sw: alu_op=00, alu_src=1, ext_op=1.
  - beq: alu_op=01; pc_we=1; npcsel=01 if zero=1, else 00; retire.
  - Next state: lw/sw -> MEM; addu/subu/ori/lui -> WB.
- MEM: lw/sw keep the EXEC ALU controls (address stable).
  - sw: mem_we=1, pc_we=1, npcsel=00, retire.
  - lw: next WB.
- WB: reg_we=1, pc_we=1, retire.
  - addu/subu: reg_dst=01, wd_sel=00, ALU controls as in EXEC.
  - ori: reg_dst=00, wd_sel=00, ALU controls as in EXEC.
  - lui: reg_dst=00, wd_sel=11.
  - lw: reg_dst=00, wd_sel=01.
  - jal: reg_dst=10, wd_sel=10, npcsel=10.
  - Non-jal: npcsel=00.
- Retire: instr_done=1, pc_we=1 in the same cycle; retired<=retired+1 on that edge, wraps modulo 2^CNT_W; next state FETCH.
- Latency in cycles, FETCH to retire inclusive: j, jr, nop, illegal 2; beq 3; jal 3; addu, subu, ori, lui, sw 4; lw 5.
- At most one retire per instruction. pc_we is never asserted outside the retire cycle.
- Reset asserted mid-instruction: state returns to FETCH immediately. Partially executed writes are not completed; any in-flight reg_we/mem_we drops asynchronously.
- illegal clears only on reset.

Test Plan:
- Reset held low 3 cycles, then released -> state=0, all enables 0, retired=0 during reset; ir_we=1 in the first cycle after release.
- Sequence ori $1,$0,5; addu $2,$1,$1; sw; lw -> retire pulses at cycles 4, 8, 12, 17; retired=4; reg_dst/wd_sel per WB rules.
- beq with zero=1 -> npcsel=01, pc_we=1 in cycle 3. With zero=0 -> npcsel=00, pc_we=1 in cycle 3.
- jal -> states 0,1,4. WB cycle: reg_we=1, reg_dst=10, wd_sel=10, npcsel=10. Then jr -> 2 cycles, npcsel=11.
- opcode 111111 -> illegal=1, retires in 2 cycles with npcsel=00. illegal stays 1 through a following addu and clears only on reset.
- reset pulled low in MEM of sw -> mem_we drops without a clock edge, no retire, retired unchanged. After release, next cycle is FETCH.
- CNT_W=4: retire 17 instructions -> retired=1.
